// File: rtl/bht_train_predictor_if.sv
// Fetch query / execute training bundle for the branch history table.
// master = fetch+execute side, slave = predictor.
interface bht_train_predictor_if #(
  parameter int PC_WIDTH = 32,
  parameter int PERF_W   = 32
);
  logic [PC_WIDTH-1:0] F_PC_i;
  logic                F_branch_i;
  logic                F_pred_taken_o;
  logic [1:0]          F_pred_cnt_o;
  logic                E_train_valid_i;
  logic [PC_WIDTH-1:0] E_train_pc_i;
  logic                E_train_taken_i;
  logic                E_train_pred_i;
  logic [PERF_W-1:0]   perf_branch_cnt_o;
  logic [PERF_W-1:0]   perf_miss_cnt_o;

  modport master (
    output F_PC_i, F_branch_i, E_train_valid_i, E_train_pc_i, E_train_taken_i, E_train_pred_i,
    input  F_pred_taken_o, F_pred_cnt_o, perf_branch_cnt_o, perf_miss_cnt_o
  );

  modport slave (
    input  F_PC_i, F_branch_i, E_train_valid_i, E_train_pc_i, E_train_taken_i, E_train_pred_i,
    output F_pred_taken_o, F_pred_cnt_o, perf_branch_cnt_o, perf_miss_cnt_o
  );
endinterface

// File: rtl/bht_train_predictor.sv
// Direct-mapped table of 2-bit saturating counters. Fetch reads combinationally;
// execute trains through a one-entry pending register that is bypassed to fetch
// and chained for back-to-back trains of the same index.
module bht_train_predictor #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         PERF_W    = 32,
  parameter int         PC_WIDTH  = 32
) (
  input logic              clk,
  input logic              rst,
  bht_train_predictor_if.slave bus
);
  localparam int ENTRIES = 2 ** BHT_IDX_W;

  logic [ENTRIES-1:0][1:0] tbl;
  logic                    pend_valid;
  logic [BHT_IDX_W-1:0]    pend_idx;
  logic [1:0]              pend_new;
  logic [PERF_W-1:0]       branch_q;
  logic [PERF_W-1:0]       miss_q;

  logic [BHT_IDX_W-1:0]    q_idx;
  logic [BHT_IDX_W-1:0]    t_idx;
  logic [1:0]              q_cnt;
  logic [1:0]              t_old;
  logic [1:0]              t_new;

  assign q_idx = bus.F_PC_i[BHT_IDX_W+1:2];
  assign t_idx = bus.E_train_pc_i[BHT_IDX_W+1:2];

  // Only the index bits of the PC matter; aliasing is allowed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.F_PC_i[PC_WIDTH-1:BHT_IDX_W+2], bus.F_PC_i[1:0],
                            bus.E_train_pc_i[PC_WIDTH-1:BHT_IDX_W+2], bus.E_train_pc_i[1:0]};

  // Fetch query: pending update wins over the (not yet written) table entry.
  always_comb begin
    q_cnt = tbl[q_idx];
    if (pend_valid && pend_idx == q_idx) q_cnt = pend_new;
  end

  assign bus.F_pred_cnt_o   = q_cnt;
  assign bus.F_pred_taken_o = bus.F_branch_i & q_cnt[1];

  // Training: chain on the pending value so consecutive same-index trains accumulate.
  always_comb begin
    t_old = tbl[t_idx];
    if (pend_valid && pend_idx == t_idx) t_old = pend_new;
    t_new = t_old;
    if (bus.E_train_taken_i) begin
      if (t_old != 2'b11) t_new = t_old + 2'b01;
    end else begin
      if (t_old != 2'b00) t_new = t_old - 2'b01;
    end
  end

  // Pending register and table write-back; reset discards any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl        <= {ENTRIES{CNT_INIT}};
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_new   <= CNT_INIT;
    end else begin
      if (pend_valid) tbl[pend_idx] <= pend_new;
      pend_valid <= bus.E_train_valid_i;
      if (bus.E_train_valid_i) begin
        pend_idx <= t_idx;
        pend_new <= t_new;
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q <= '0;
      miss_q   <= '0;
    end else if (bus.E_train_valid_i) begin
      branch_q <= branch_q + 1'b1;
      if (bus.E_train_taken_i != bus.E_train_pred_i) miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.perf_branch_cnt_o = branch_q;
  assign bus.perf_miss_cnt_o   = miss_q;
endmodule

// File: tb/tb_bht_train_predictor.sv
// Directed bench for bht_train_predictor: per-cycle vector table plus
// hand sequences for reset-during-pending and perf counter wrap.
module tb_bht_train_predictor;
  logic clk;
  logic rst;

  bht_train_predictor_if #(.PC_WIDTH(32), .PERF_W(32)) bus ();
  bht_train_predictor_if #(.PC_WIDTH(32), .PERF_W(4))  bus4 ();

  bht_train_predictor #(.BHT_IDX_W(6), .CNT_INIT(2'b01), .PERF_W(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Narrow perf counters so the wrap is reachable in a few cycles.
  bht_train_predictor #(.BHT_IDX_W(6), .CNT_INIT(2'b01), .PERF_W(4), .PC_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        tv;
    logic [31:0] tpc;
    logic        tt;
    logic        tp;
    logic [31:0] qpc;
    logic        qbr;
    logic [1:0]  e_cnt;
    logic        e_taken;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } vec_t;

  vec_t v[20];

  task automatic idle_inputs();
    bus.F_PC_i = 32'h0; bus.F_branch_i = 1'b0;
    bus.E_train_valid_i = 1'b0; bus.E_train_pc_i = 32'h0;
    bus.E_train_taken_i = 1'b0; bus.E_train_pred_i = 1'b0;
    bus4.F_PC_i = 32'h0; bus4.F_branch_i = 1'b0;
    bus4.E_train_valid_i = 1'b0; bus4.E_train_pc_i = 32'h0;
    bus4.E_train_taken_i = 1'b0; bus4.E_train_pred_i = 1'b0;
  endtask

  initial begin
    //        tv  tpc           tt  tp  qpc           qbr cnt    tk  br  miss
    v[0]  = '{0, 32'h0,        0, 0, 32'h80000000, 1, 2'b01, 0, 0,  0};
    v[1]  = '{1, 32'h80000010, 1, 0, 32'h80000010, 1, 2'b01, 0, 0,  0};
    v[2]  = '{0, 32'h0,        0, 0, 32'h80000010, 1, 2'b10, 1, 1,  1};
    v[3]  = '{0, 32'h0,        0, 0, 32'h80000010, 1, 2'b10, 1, 1,  1};
    v[4]  = '{1, 32'h80000010, 1, 1, 32'h80000000, 1, 2'b01, 0, 1,  1};
    v[5]  = '{0, 32'h0,        0, 0, 32'h80000010, 1, 2'b11, 1, 2,  1};
    v[6]  = '{1, 32'h80000010, 1, 1, 32'h80000010, 1, 2'b11, 1, 2,  1};
    v[7]  = '{0, 32'h0,        0, 0, 32'h80000010, 1, 2'b11, 1, 3,  1};
    v[8]  = '{1, 32'h80000020, 0, 1, 32'h80000020, 1, 2'b01, 0, 3,  1};
    v[9]  = '{1, 32'h80000020, 0, 0, 32'h80000020, 1, 2'b00, 0, 4,  2};
    v[10] = '{1, 32'h80000020, 0, 0, 32'h80000020, 1, 2'b00, 0, 5,  2};
    v[11] = '{0, 32'h0,        0, 0, 32'h80000020, 1, 2'b00, 0, 6,  2};
    v[12] = '{0, 32'h0,        0, 0, 32'h80000020, 1, 2'b00, 0, 6,  2};
    v[13] = '{1, 32'h80000004, 1, 0, 32'h80000104, 0, 2'b01, 0, 6,  2};
    v[14] = '{0, 32'h0,        0, 0, 32'h80000104, 0, 2'b10, 0, 7,  3};
    v[15] = '{0, 32'h0,        0, 0, 32'h80000104, 1, 2'b10, 1, 7,  3};
    v[16] = '{1, 32'h80000030, 1, 1, 32'h80000030, 1, 2'b01, 0, 7,  3};
    v[17] = '{1, 32'h80000030, 1, 1, 32'h80000030, 1, 2'b10, 1, 8,  3};
    v[18] = '{1, 32'h80000030, 1, 1, 32'h80000030, 1, 2'b11, 1, 9,  3};
    v[19] = '{0, 32'h0,        0, 0, 32'h80000030, 1, 2'b11, 1, 10, 3};

    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_branch_cnt", bus.perf_branch_cnt_o, 32'd0);
    chk("rst_miss_cnt",   bus.perf_miss_cnt_o,   32'd0);
    #10 rst = 1'b0;

    // Vector table: inputs applied just after a rising edge, outputs checked 1ns later.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.E_train_valid_i = v[i].tv;
      bus.E_train_pc_i    = v[i].tpc;
      bus.E_train_taken_i = v[i].tt;
      bus.E_train_pred_i  = v[i].tp;
      bus.F_PC_i          = v[i].qpc;
      bus.F_branch_i      = v[i].qbr;
      #1;
      chk($sformatf("v%0d_cnt", i),   {30'd0, bus.F_pred_cnt_o},   {30'd0, v[i].e_cnt});
      chk($sformatf("v%0d_taken", i), {31'd0, bus.F_pred_taken_o}, {31'd0, v[i].e_taken});
      chk($sformatf("v%0d_branch", i), bus.perf_branch_cnt_o, v[i].e_br);
      chk($sformatf("v%0d_miss", i),   bus.perf_miss_cnt_o,   v[i].e_miss);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset while an update is pending: the update must be dropped.
    bus.E_train_valid_i = 1'b1; bus.E_train_pc_i = 32'h80000040;
    bus.E_train_taken_i = 1'b1; bus.E_train_pred_i = 1'b0;
    bus.F_PC_i = 32'h80000040; bus.F_branch_i = 1'b1;
    @(posedge clk); #1;
    bus.E_train_valid_i = 1'b0;
    #1;
    chk("pend_bypass_cnt", {30'd0, bus.F_pred_cnt_o}, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("rst_pend_cnt",    {30'd0, bus.F_pred_cnt_o}, 32'd1);
    chk("rst_pend_taken",  {31'd0, bus.F_pred_taken_o}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_cnt",   {30'd0, bus.F_pred_cnt_o}, 32'd1);
    chk("after_rst_branch", bus.perf_branch_cnt_o, 32'd0);
    bus.F_PC_i = 32'h80000010;
    #1;
    chk("after_rst_tbl_idx4", {30'd0, bus.F_pred_cnt_o}, 32'd1);
    @(posedge clk); #1;

    // Perf wrap on the 4-bit instance: 15 mispredicted trains, then one more.
    bus4.E_train_pc_i = 32'h80000050;
    bus4.E_train_taken_i = 1'b1; bus4.E_train_pred_i = 1'b0;
    bus4.E_train_valid_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    bus4.E_train_valid_i = 1'b0;
    #1;
    chk("perf4_branch_max", {28'd0, bus4.perf_branch_cnt_o}, 32'd15);
    chk("perf4_miss_max",   {28'd0, bus4.perf_miss_cnt_o},   32'd15);
    bus4.E_train_valid_i = 1'b1;
    @(posedge clk); #1;
    bus4.E_train_valid_i = 1'b0;
    #1;
    chk("perf4_branch_wrap", {28'd0, bus4.perf_branch_cnt_o}, 32'd0);
    chk("perf4_miss_wrap",   {28'd0, bus4.perf_miss_cnt_o},   32'd0);
    bus4.F_PC_i = 32'h80000050; bus4.F_branch_i = 1'b1;
    #1;
    chk("perf4_sat_cnt",   {30'd0, bus4.F_pred_cnt_o},   32'd3);
    chk("perf4_sat_taken", {31'd0, bus4.F_pred_taken_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
